nr_divider_seq: RTL and testbench

- Sequential, parametrised unsigned non-restoring divider. Replaces the flat combinational array with one iterative add/subtract stage that retires one quotient bit per clock.
- Valid/ready handshake on both input and output, a final remainder-correction step, and divide-by-zero detection.
- Sits between operand-producing datapath logic and result consumers that can apply backpressure.

---
 rtl/nr_divider_seq.sv | 139 +++++++++++++
 tb/tb_nr_divider_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nr_divider_seq.sv
// Sequential unsigned non-restoring divider that retires one quotient bit per clock.
// It has valid/ready handshakes on both sides, a final remainder fix-up, and divide-by-zero detection.
module nr_divider_seq #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q;
    logic [N:0]     p_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]   quot_q;
    logic [N-1:0]   rem_q;
    logic           dbz_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [N:0]     shift_p_s;
    logic [N:0]     p_d;
    logic [N-1:0]   a_d;
    logic [N-1:0]   fix_r_d;

    // One add/subtract iteration plus the final remainder correction.
    // The correction is done modulo 2^N: the corrected value always lies in [0, D).
    always_comb begin
        shift_p_s = {p_q[N-1:0], a_q[N-1]};
        if (!p_q[N]) begin
            p_d = shift_p_s - {1'b0, d_q};
        end else begin
            p_d = shift_p_s + {1'b0, d_q};
        end
        a_d = {a_q[N-2:0], ~p_d[N]};
        if (p_q[N]) begin
            fix_r_d = p_q[N-1:0] + d_q;
        end else begin
            fix_r_d = p_q[N-1:0];
        end
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            a_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        p_q        <= '0;
                        a_q        <= dividend;
                        d_q        <= divisor;
                        cnt_q      <= CNT_W'(N);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    a_q   <= a_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q  <= a_q;
                    rem_q   <= fix_r_d;
                    dbz_q   <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    // out_valid rises one cycle after DONE is entered.
                    // It then drops on the edge that completes the handshake.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_nr_divider_seq.sv
// Scoreboard bench for nr_divider_seq (N=8): directed cases plus randomised operands checked
// against plain integer division; a negedge monitor compares every presented result.
module tb_nr_divider_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    nr_divider_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int dbz;
        int acc;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   rand_mode = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Randomised consumer backpressure during the random phase.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare presented results against the head of the scoreboard.
    initial begin
        bit prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        chk("quotient", int'(quotient), exp_q[0].q);
                        chk("remainder", int'(remainder), exp_q[0].r);
                        chk("div_by_zero", int'(div_by_zero), exp_q[0].dbz);
                        if (!prev_ov) chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   w = 0;
        while (!in_ready && w < 200) begin
            step();
            w++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        if (b == '0) begin
            e.q = (1 << N) - 1; e.r = int'(a); e.dbz = 1; e.lat = 1;
        end else begin
            e.q = int'(a) / int'(b); e.r = int'(a) % int'(b); e.dbz = 0; e.lat = N + 2;
        end
        e.acc = cyc + 1;
        exp_q.push_back(e);
        step();
        in_valid = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 300) begin
            step();
            w++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return N'(1);
            2:       return '1;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state.
        repeat (3) step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // 100/7 with in_ready timing.
        issue(8'd100, 8'd7);
        for (int k = 1; k <= 10; k++) chk("in_ready_busy", int'(in_ready), 0);
        for (int k = 1; k <= 10; k++) if (k < 10) step();
        step();
        step();
        chk("in_ready_after", int'(in_ready), 1);

        // Back-to-back boundary operands.
        issue(8'd255, 8'd1);
        issue(8'd5, 8'd9);
        issue(8'd255, 8'd255);
        issue(8'd0, 8'd13);
        drain();

        // Divide by zero.
        issue(8'd37, 8'd0);
        drain();

        // Backpressure with an ignored second request.
        out_ready = 1'b0;
        issue(8'd200, 8'd3);
        for (int w = 0; w < 40 && !out_valid; w++) step();
        chk("bp_out_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_consumed", int'(out_valid), 0);
        chk("bp_in_ready_next", int'(in_ready), 1);
        chk("bp_queue", exp_q.size(), 0);

        // Reset in the middle of CALC aborts the operation.
        issue(8'd250, 8'd6);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        issue(8'd250, 8'd6);
        drain();

        // Random operands with random backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            issue(pick(), pick());
        end
        rand_mode = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
